sd_cmd_responder: RTL
=====================

Name: sd_cmd_responder

Overview:
Card-side CMD-line engine, the counterpart of the host cmd_driver. Used as the SD card model in the GhostSD verification environment and as a reusable card front end.
- Deserialises 48-bit host commands and checks the end bit and CRC7.
- Presents each valid command to card logic, waits the Ncr gap, then serialises a 48-bit R1/R3/R6/R7-format response back onto CMD.
- R2 (136-bit) responses are out of scope.

Parameters:
NCR, 2, minimum idle bit periods between command end bit and response start bit (legal 2..64)
RESP_TIMEOUT, 64, cycles after ocmd_valid to wait for iresp_valid before dropping the response

Ports:
iclk  in  1  SD CLK; CMD sampled and driven on rising edge
irst  in  1  synchronous, active-low reset
icmd_sd  in  1  CMD line from host
ocmd_sd  out  1  CMD line to host; 1 when not driving
ocmd_oe  out  1  CMD output enable
ocmd_valid  out  1  one-cycle pulse: command received intact
ocmd_index  out  6  received command index, held until next valid command
ocmd_arg  out  32  received argument, held until next valid command
iresp_valid  in  1  card logic supplies response (sampled only in WAIT_RESP)
iresp_type  in  2  00 none, 01 R1-format (echo index, computed CRC7), 10 R3-format (index and CRC all ones), 11 treated as none
iresp_arg  in  32  response content bits [39:8]
ocrc_err  out  1  one-cycle pulse: command CRC7 mismatch
oframe_err  out  1  one-cycle pulse: transmission bit 0 or end bit 0
obusy  out  1  high in any state except IDLE

Behaviour:
- Reset (irst=0 at edge) overrides everything, including mid-receive and mid-transmit.
  - Outputs after reset: ocmd_sd=1, ocmd_oe=0, ocmd_valid=0, ocmd_index=0, ocmd_arg=0, ocrc_err=0, oframe_err=0, obusy=0; state IDLE.
- States: IDLE -> RX -> CHECK -> WAIT_RESP -> GAP -> TX -> IDLE.
- IDLE: icmd_sd=0 sampled -> start bit (frame bit 47); go RX with bit counter 46.
- RX: shift one bit per edge down to bit 0 (end bit); go CHECK. CRC7 runs over frame bits 47..8.
  - Polynomial x^7+x^3+1, init 0, MSB first.
- CHECK (one cycle), first matching condition wins:
  - bit46!=1 or end bit!=1 -> oframe_err pulse -> IDLE.
  - CRC7 != bits 7..1 -> ocrc_err pulse -> IDLE.
  - Otherwise latch ocmd_index/ocmd_arg, pulse ocmd_valid -> WAIT_RESP.
  - All pulses are registered, high for exactly one cycle.
- WAIT_RESP: counter starts at the ocmd_valid cycle.
  - iresp_valid=1 with type 00/11 -> IDLE.
  - Type 01/10 -> latch type and arg, go GAP.
  - RESP_TIMEOUT cycles without iresp_valid -> IDLE, nothing driven.
- GAP/TX timing (end bit sampled at edge E):
  - Response start bit is driven from edge E+NCR+1 if iresp_valid is seen at or before edge E+NCR.
  - Otherwise the start bit is driven one edge after the iresp_valid sample.
  - ocmd_oe rises with the start bit.
- TX: 48 bits MSB first, one per edge.
  - Frame: start 0, transmission 0, index (R1: received index; R3: 111111), arg[31:0], CRC7 (R1: computed over the first 40 response bits; R3: 1111111), end 1.
  - Edge after the end bit: ocmd_oe=0, ocmd_sd=1, IDLE.
- icmd_sd is ignored in CHECK, WAIT_RESP, GAP and TX; a new command is recognised only from IDLE.
- ocmd_index/ocmd_arg change only on a valid command; an errored frame leaves previous values intact.

Test Plan:
- CMD0: host frame 0x40_00000000_95 -> ocmd_valid one cycle, index 0, arg 0; card iresp_type=00 -> ocmd_oe stays 0, back to IDLE.
- CMD8 arg 0x000001AA (frame 0x48_000001AA_87), iresp_type=01, arg 0x000001AA at ocmd_valid -> after exactly NCR=2 idle bits, ocmd_sd shifts 0x08_000001AA_13; oe drops after end bit.
- ACMD41 response: iresp_type=10, arg 0x80FF8000 -> response 0x3F_80FF8000_FF.
- CMD55 frame with CRC byte 0x65 corrupted to 0x67 -> ocrc_err pulse, no ocmd_valid, index/arg unchanged, no drive. End bit forced 0 -> oframe_err pulse only.
- No iresp_valid for RESP_TIMEOUT=64 cycles -> IDLE, oe never asserted. Next CMD0 accepted normally.
- irst=0 at response bit 20 -> next edge ocmd_oe=0, ocmd_sd=1, obusy=0. A following CMD8 is received and answered correctly.

Source files
------------

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD-line engine: receives 48-bit host commands, checks framing and
// CRC7, hands valid commands to card logic and serialises a 48-bit response back.
module sd_cmd_responder #(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        icmd_sd,
  output logic        ocmd_sd,
  output logic        ocmd_oe,
  output logic        ocmd_valid,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  input  logic        iresp_valid,
  input  logic [1:0]  iresp_type,
  input  logic [31:0] iresp_arg,
  output logic        ocrc_err,
  output logic        oframe_err,
  output logic        obusy,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RX        = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_TX        = 3'd5;

  logic [2:0]  state;
  logic [5:0]  bit_cnt;
  logic [47:0] rx_shreg;
  logic [7:0]  wait_cnt;
  logic [6:0]  elapsed;
  logic        resp_r3;
  logic [31:0] resp_arg;
  logic        tx_last;

  logic [6:0]  rx_crc;
  logic [39:0] tx_head;
  logic [6:0]  tx_crc;
  logic [47:0] tx_frame;

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // The response frame is rebuilt from the latched type/arg and the held command index.
  always_comb begin
    rx_crc   = crc7_40(rx_shreg[47:8]);
    tx_head  = {2'b00, (resp_r3 ? 6'h3f : ocmd_index), resp_arg};
    tx_crc   = resp_r3 ? 7'h7f : crc7_40(tx_head);
    tx_frame = {tx_head, tx_crc, 1'b1};
  end

  assign obusy     = (state != S_IDLE);
  assign dbg_state = state;

  // Handshake: ocmd_valid is a one-cycle pulse; card logic answers by holding
  // iresp_valid high for at least one cycle while in WAIT_RESP, there is no ready.
  always_ff @(posedge iclk) begin
    if (!irst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      rx_shreg   <= '0;
      wait_cnt   <= '0;
      elapsed    <= '0;
      resp_r3    <= 1'b0;
      resp_arg   <= '0;
      tx_last    <= 1'b0;
      ocmd_sd    <= 1'b1;
      ocmd_oe    <= 1'b0;
      ocmd_valid <= 1'b0;
      ocmd_index <= '0;
      ocmd_arg   <= '0;
      ocrc_err   <= 1'b0;
      oframe_err <= 1'b0;
    end else begin
      ocmd_valid <= 1'b0;
      ocrc_err   <= 1'b0;
      oframe_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!icmd_sd) begin
            rx_shreg <= '0;
            bit_cnt  <= 6'd46;
            state    <= S_RX;
          end
        end
        S_RX: begin
          rx_shreg <= {rx_shreg[46:0], icmd_sd};
          if (bit_cnt == 6'd0) state <= S_CHECK;
          else bit_cnt <= bit_cnt - 6'd1;
        end
        S_CHECK: begin
          if (!rx_shreg[46] || !rx_shreg[0]) begin
            oframe_err <= 1'b1;
            state      <= S_IDLE;
          end else if (rx_crc != rx_shreg[7:1]) begin
            ocrc_err <= 1'b1;
            state    <= S_IDLE;
          end else begin
            ocmd_index <= rx_shreg[45:40];
            ocmd_arg   <= rx_shreg[39:8];
            ocmd_valid <= 1'b1;
            wait_cnt   <= '0;
            elapsed    <= 7'd2;  // next edge is two after the end-bit edge
            state      <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (elapsed != 7'h7f) elapsed <= elapsed + 7'd1;
          if (iresp_valid) begin
            if (iresp_type == 2'b01 || iresp_type == 2'b10) begin
              resp_r3  <= iresp_type[1];
              resp_arg <= iresp_arg;
              state    <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end else if (wait_cnt == 8'(RESP_TIMEOUT - 1)) begin
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_GAP: begin
          // elapsed holds the index of the current edge relative to the end-bit edge
          if (elapsed >= 7'(NCR + 1)) begin
            ocmd_sd <= tx_frame[47];
            ocmd_oe <= 1'b1;
            bit_cnt <= 6'd46;
            tx_last <= 1'b0;
            state   <= S_TX;
          end else begin
            elapsed <= elapsed + 7'd1;
          end
        end
        S_TX: begin
          if (tx_last) begin
            ocmd_oe <= 1'b0;
            ocmd_sd <= 1'b1;
            state   <= S_IDLE;
          end else begin
            ocmd_sd <= tx_frame[bit_cnt];
            if (bit_cnt == 6'd0) tx_last <= 1'b1;
            else bit_cnt <= bit_cnt - 6'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
